// File: rtl/sevenseg_pkg.sv
// Shared segment patterns and the code-to-segment decode function for the
// seven-segment scan driver. Patterns are active-high, bit 6 = segment a.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_DASH  = 7'h01;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes 10-15 fall back to a dash when hex display is disabled.
  function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex_en);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = hex_en ? SEG_A : SEG_DASH;
      4'hB:    pat = hex_en ? SEG_B : SEG_DASH;
      4'hC:    pat = hex_en ? SEG_C : SEG_DASH;
      4'hD:    pat = hex_en ? SEG_D : SEG_DASH;
      4'hE:    pat = hex_en ? SEG_E : SEG_DASH;
      default: pat = hex_en ? SEG_F : SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Display-side bundle of the scan driver: digit/dp data, load strobe, enable,
// and the active-low pin outputs plus the frame pulse.
interface sevenseg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    enable;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output digits,
    output dp_in,
    output load,
    output enable,
    input  seg,
    input  dp,
    input  an,
    input  frame_done
  );

  modport slave (
    input  digits,
    input  dp_in,
    input  load,
    input  enable,
    output seg,
    output dp,
    output an,
    output frame_done
  );

endinterface

// File: rtl/sevenseg_dec.sv
// Combinational digit-code to active-high segment pattern decoder.
module sevenseg_dec #(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  import sevenseg_pkg::*;

  always_comb begin
    seg_o = seg_decode(code_i, HEX_EN);
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered
// digits, leading-zero suppression, anode guard interval and registered pins.
module sevenseg_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD_CYC   = 1000,
  parameter bit          HEX_EN      = 1'b0,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input logic            clk,
  input logic            rst,
  sevenseg_scan_if.slave bus
);
  import sevenseg_pkg::*;

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DigW = 4 * NUM_DIGITS;

  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD_CYC);

  if (NUM_DIGITS < 1) begin : g_chk_digits
    $error("NUM_DIGITS must be at least 1");
  end
  if (REFRESH_DIV < 2) begin : g_chk_div
    $error("REFRESH_DIV must be at least 2");
  end
  if (GUARD_CYC >= REFRESH_DIV) begin : g_chk_guard
    $error("GUARD_CYC must be below REFRESH_DIV");
  end

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DigW-1:0]       shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DigW-1:0]       active_dig_q, active_dig_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  an_on;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  upper_zero;

  // Slot and frame sequencing.
  always_comb begin
    slot_end  = (cnt_q == CntMax);
    frame_end = slot_end && (idx_q == IdxMax);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // The active buffer only changes on a frame boundary so a frame never tears;
  // a load landing on the boundary itself bypasses the shadow.
  always_comb begin
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    active_dig_d = active_dig_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    if (bus.load) begin
      shadow_dig_d = bus.digits;
      shadow_dp_d  = bus.dp_in;
      pending_d    = 1'b1;
    end
    if (frame_end) begin
      if (bus.load) begin
        active_dig_d = bus.digits;
        active_dp_d  = bus.dp_in;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        active_dig_d = shadow_dig_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
      end
    end
  end

  // A digit is suppressed when it and all higher digits are zero; digit 0 never is.
  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      upper_zero    = upper_zero && (active_dig_q[4*k +: 4] == 4'h0);
      blank_mask[k] = LZ_BLANK && upper_zero && (k != 0);
    end
  end

  always_comb begin
    cur_code = active_dig_q[{idx_q, 2'b00} +: 4];
    cur_dp   = active_dp_q[idx_q];
  end

  sevenseg_dec #(
    .HEX_EN (HEX_EN)
  ) u_dec (
    .code_i (cur_code),
    .seg_o  (dec_seg)
  );

  // Segments and dp are held dark whenever no anode is driven.
  always_comb begin
    an_on        = bus.enable && (cnt_q >= GuardCnt);
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    an_d         = '1;
    frame_done_d = frame_end;
    if (an_on) begin
      seg_d       = blank_mask[idx_q] ? ~SEG_BLANK : ~dec_seg;
      dp_d        = ~cur_dp;
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      active_dig_q <= active_dig_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2;
// two instances differ only in HEX_EN and share all stimulus.
module tb_sevenseg_scan;

  localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  sevenseg_scan_if #(.NUM_DIGITS(4)) bus0 ();
  sevenseg_scan_if #(.NUM_DIGITS(4)) bus1 ();

  assign bus1.digits = bus0.digits;
  assign bus1.dp_in  = bus0.dp_in;
  assign bus1.load   = bus0.load;
  assign bus1.enable = bus0.enable;

  sevenseg_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .GUARD_CYC   (2),
    .HEX_EN      (1'b0),
    .LZ_BLANK    (1'b1)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sevenseg_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .GUARD_CYC   (2),
    .HEX_EN      (1'b1),
    .LZ_BLANK    (1'b1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of edges since reset release; after edge e outputs reflect state e-1.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus0.load    = 1'b0;
    bus0.enable  = 1'b1;
    bus0.digits  = '0;
    bus0.dp_in   = '0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] dpv);
    bus0.digits = d;
    bus0.dp_in  = dpv;
    bus0.load   = 1'b1;
    tick();
    bus0.load   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.enable = 1'b1;
    bus0.load = 1'b0;
    tick();
    tick();
    checks++;
    if (bus0.seg !== 7'h7F) begin
      errors++; $display("FAIL reset_seg: got %b want %b", bus0.seg, 7'h7F);
    end
    checks++;
    if (bus0.dp !== 1'b1) begin
      errors++; $display("FAIL reset_dp: got %b want 1", bus0.dp);
    end
    checks++;
    if (bus0.an !== 4'hF) begin
      errors++; $display("FAIL reset_an: got %b want 1111", bus0.an);
    end
    checks++;
    if (bus0.frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done: got %b want 0", bus0.frame_done);
    end
  endtask

  task automatic test_scan_idle();
    do_reset();
    run_to(2);
    checks++;
    if (bus0.an !== 4'hF) begin
      errors++; $display("FAIL idle_guard_an: got %b want 1111", bus0.an);
    end
    run_to(3);
    checks++;
    if (bus0.an !== 4'b1110 || bus0.seg !== 7'b0000001) begin
      errors++; $display("FAIL idle_first_on: got an=%b seg=%b want an=1110 seg=0000001",
                         bus0.an, bus0.seg);
    end
    for (int k = 1; k < 4; k++) begin
      run_to(5 + 8 * k);
      checks++;
      if (bus0.an !== AN_TAB[k] || bus0.seg !== 7'h7F) begin
        errors++; $display("FAIL idle_blank_d%0d: got an=%b seg=%b want an=%b seg=1111111",
                           k, bus0.an, bus0.seg, AN_TAB[k]);
      end
    end
    run_to(31);
    checks++;
    if (bus0.frame_done !== 1'b0) begin
      errors++; $display("FAIL idle_fd_early: got %b want 0", bus0.frame_done);
    end
    for (int f = 1; f <= 2; f++) begin
      run_to(32 * f);
      checks++;
      if (bus0.frame_done !== 1'b1) begin
        errors++; $display("FAIL idle_fd_pulse%0d: got %b want 1", f, bus0.frame_done);
      end
      tick();
      checks++;
      if (bus0.frame_done !== 1'b0) begin
        errors++; $display("FAIL idle_fd_clear%0d: got %b want 0", f, bus0.frame_done);
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] exp_seg [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    load_val(16'h1234, 4'b0100);
    run_to(5);
    checks++;
    if (bus0.seg !== 7'b0000001) begin
      errors++; $display("FAIL basic_old_frame: got %b want 0000001", bus0.seg);
    end
    run_to(33);
    checks++;
    if (bus0.an !== 4'hF || bus0.seg !== 7'h7F || bus0.dp !== 1'b1) begin
      errors++; $display("FAIL basic_guard: got an=%b seg=%b dp=%b want 1111/1111111/1",
                         bus0.an, bus0.seg, bus0.dp);
    end
    for (int k = 0; k < 4; k++) begin
      run_to(37 + 8 * k);
      checks++;
      if (bus0.seg !== exp_seg[k] || bus0.an !== AN_TAB[k] || bus0.dp !== exp_dp[k]) begin
        errors++; $display("FAIL basic_d%0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                           k, bus0.seg, bus0.an, bus0.dp, exp_seg[k], AN_TAB[k], exp_dp[k]);
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] exp0 [4] = '{7'b0100100, 7'b1111110, 7'h7F, 7'h7F};
    logic [6:0] exp1 [4] = '{7'b0100100, 7'b0001000, 7'h7F, 7'h7F};
    do_reset();
    load_val(16'h00A5, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      run_to(37 + 8 * k);
      checks++;
      if (bus0.seg !== exp0[k] || bus0.an !== AN_TAB[k]) begin
        errors++; $display("FAIL hex0_d%0d: got seg=%b an=%b want seg=%b an=%b",
                           k, bus0.seg, bus0.an, exp0[k], AN_TAB[k]);
      end
      checks++;
      if (bus1.seg !== exp1[k]) begin
        errors++; $display("FAIL hex1_d%0d: got seg=%b want %b", k, bus1.seg, exp1[k]);
      end
    end
  endtask

  task automatic test_tear_free();
    do_reset();
    load_val(16'h5555, 4'b0000);
    run_to(41);
    load_val(16'h1111, 4'b0000);
    run_to(43);
    load_val(16'h2222, 4'b0000);
    for (int k = 1; k < 4; k++) begin
      run_to(37 + 8 * k);
      checks++;
      if (bus0.seg !== 7'b0100100) begin
        errors++; $display("FAIL tear_cur_d%0d: got %b want 0100100", k, bus0.seg);
      end
    end
    for (int k = 0; k < 4; k++) begin
      run_to(69 + 8 * k);
      checks++;
      if (bus0.seg !== 7'b0010010 || bus0.an !== AN_TAB[k]) begin
        errors++; $display("FAIL tear_next_d%0d: got seg=%b an=%b want seg=0010010 an=%b",
                           k, bus0.seg, bus0.an, AN_TAB[k]);
      end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    run_to(29);
    checks++;
    if (bus0.seg !== 7'h7F || bus0.an !== 4'b0111) begin
      errors++; $display("FAIL bypass_pre: got seg=%b an=%b want 1111111/0111",
                         bus0.seg, bus0.an);
    end
    run_to(31);
    load_val(16'h9999, 4'b1000);
    for (int f = 1; f <= 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        run_to(32 * f + 5 + 8 * k);
        checks++;
        if (bus0.seg !== 7'b0000100 || bus0.dp !== (k != 3)) begin
          errors++; $display("FAIL bypass_f%0d_d%0d: got seg=%b dp=%b want seg=0000100 dp=%b",
                             f, k, bus0.seg, bus0.dp, (k != 3));
        end
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    load_val(16'h0008, 4'b0001);
    run_to(11);
    bus0.enable = 1'b0;
    run_to(12);
    checks++;
    if (bus0.an !== 4'hF || bus0.seg !== 7'h7F) begin
      errors++; $display("FAIL enable_off_a: got an=%b seg=%b want 1111/1111111",
                         bus0.an, bus0.seg);
    end
    run_to(16);
    checks++;
    if (bus0.an !== 4'hF || bus0.dp !== 1'b1) begin
      errors++; $display("FAIL enable_off_b: got an=%b dp=%b want 1111/1", bus0.an, bus0.dp);
    end
    bus0.enable = 1'b1;
    run_to(21);
    checks++;
    if (bus0.an !== 4'b1011) begin
      errors++; $display("FAIL enable_phase: got an=%b want 1011", bus0.an);
    end
    run_to(31);
    checks++;
    if (bus0.frame_done !== 1'b0) begin
      errors++; $display("FAIL enable_fd_early: got %b want 0", bus0.frame_done);
    end
    run_to(32);
    checks++;
    if (bus0.frame_done !== 1'b1) begin
      errors++; $display("FAIL enable_fd_pulse: got %b want 1", bus0.frame_done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_val(16'h7777, 4'b1111);
    run_to(19);
    checks++;
    if (bus0.an !== 4'b1011) begin
      errors++; $display("FAIL rstmid_pre: got an=%b want 1011", bus0.an);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus0.an !== 4'hF || bus0.seg !== 7'h7F || bus0.dp !== 1'b1
        || bus0.frame_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got an=%b seg=%b dp=%b fd=%b want reset values",
                         bus0.an, bus0.seg, bus0.dp, bus0.frame_done);
    end
    rst = 1'b0;
    cyc = 0;
    run_to(3);
    checks++;
    if (bus0.an !== 4'b1110 || bus0.seg !== 7'b0000001) begin
      errors++; $display("FAIL rstmid_restart: got an=%b seg=%b want 1110/0000001",
                         bus0.an, bus0.seg);
    end
    run_to(37);
    checks++;
    if (bus0.seg !== 7'b0000001 || bus0.dp !== 1'b1) begin
      errors++; $display("FAIL rstmid_discard_d0: got seg=%b dp=%b want 0000001/1",
                         bus0.seg, bus0.dp);
    end
    run_to(45);
    checks++;
    if (bus0.seg !== 7'h7F) begin
      errors++; $display("FAIL rstmid_discard_d1: got seg=%b want 1111111", bus0.seg);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    rst         = 1'b1;
    bus0.load   = 1'b0;
    bus0.enable = 1'b1;
    bus0.digits = '0;
    bus0.dp_in  = '0;
    test_reset();
    test_scan_idle();
    test_basic();
    test_hex();
    test_tear_free();
    test_bypass();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a double-buffered BCD/hex value and scans one digit per refresh slot. It applies leading-zero suppression, per-digit decimal points and an anode guard interval against ghosting, and drives active-low segment and anode lines directly. It sits between the counter/datapath logic (e.g. the coin counter) and the board display pins, replacing per-digit static decoders.

## Interface
- NUM_DIGITS, 4: digits scanned; ≥1.
- REFRESH_DIV, 100000: clk cycles per digit slot; ≥2.
- GUARD_CYC, 1000: cycles at slot start with all anodes off; 0 ≤ GUARD_CYC < REFRESH_DIV.
- HEX_EN, 0: 1 = codes 10–15 show A,b,C,d,E,F; 0 = show dash (segment g only).
- LZ_BLANK, 1: 1 = leading-zero suppression enabled.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- digits  in  4*NUM_DIGITS  digit codes; digit 0 in bits [3:0] (least significant).
- dp_in  in  NUM_DIGITS  decimal point per digit, active-high.
- load  in  1  single-cycle strobe; captures digits/dp_in into shadow.
- enable  in  1  0 = all anodes off; scanning continues.
- seg  out  7  {a,b,c,d,e,f,g}, a = bit 6, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anode selects, active-low, at most one low.
- frame_done  out  1  one-cycle pulse at end of each full scan.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. Slot index idx increments when cnt = REFRESH_DIV-1, wrapping NUM_DIGITS-1 → 0.
- Frame boundary: cnt = REFRESH_DIV-1 and idx = NUM_DIGITS-1. frame_done is registered high for the cycle after this state.
- Double buffer:
  - load writes shadow and sets pending.
  - At a frame boundary with pending set, shadow is copied to active and pending is cleared.
  - load on the frame-boundary cycle itself: the incoming digits/dp_in go straight to active (bypass), and pending ends cleared.
  - Updates never change the displayed value mid-frame.
- Decode of active digit idx (digit 0 = LSD):
  - 0–9: standard patterns (0 → a..f lit; 1 → b,c; 8 → all).
  - 10–15: per HEX_EN.
  - Blank: all segments off.
- Leading-zero suppression (LZ_BLANK=1):
  - Digit k is blank if it and every higher digit equal 0.
  - Digit 0 is never suppressed.
  - A lit dp on a suppressed digit is still shown.
- an[idx] is low when enable=1 and cnt ≥ GUARD_CYC; otherwise all anodes are high.
- seg and dp are forced high while all anodes are high.

## Timing
- All outputs are registered: outputs at cycle t+1 reflect cnt/idx/active at cycle t.
- Reset: seg=7'h7F, dp=1, an=all 1, frame_done=0, cnt=0, idx=0, shadow=active=0, pending=0.
- After reset release, the first anode goes low GUARD_CYC+1 cycles later; with LZ_BLANK, digit 0 shows "0".
- Load-to-display latency: from 1 cycle up to NUM_DIGITS·REFRESH_DIV cycles, plus 1 cycle output register.
- Multiple loads within one frame: the last load wins.
- rst asserted mid-scan: at the next edge all state returns to reset values, and any pending update is discarded.
- enable toggling does not reset cnt/idx; the frame phase is preserved.

## Structure
- Package sevenseg_pkg holds:
  - SEG_* 7-bit active-high pattern constants for 0–9, A–F, dash and blank.
  - Function seg_decode(code, hex_en) returning the 7-bit pattern.
- Sub-module sevenseg_dec: combinational code-to-pattern decoder using the package function, instantiated once on the muxed digit.
- Top sevenseg_scan contains the prescaler, slot counter, shadow/active buffers, LZ mask and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2.
- Reset/scan: release rst with enable=1 and no load → an low during cycles 3..8 (an=4'b1110), seg=7'b0000001 ("0"); digits 1–3 are blank (seg=7'h7F) in their slots; frame_done pulses every 32 cycles.
- Basic display: load digits=16'h1234, dp_in=4'b0100 → next frame shows "4","3","2","1" on an 1110/1101/1011/0111; dp=0 only in the digit-2 slot.
- Leading zero/hex: load 16'h00A5 with HEX_EN=0 → digit 1 shows dash (7'b1111110), digits 2–3 blank. Repeat with HEX_EN=1 → digit 1 shows "A" (7'b0001000).
- Tear-free: load 16'h1111 mid-frame, then 16'h2222 two cycles later → current frame unchanged; next frame all "2".
- Boundary bypass: load 16'h9999 exactly on the frame-boundary cycle → next frame shows "9999"; pending stays 0.
- Reset/enable mid-operation: drop enable for 5 cycles → an=all 1 and seg=7'h7F, with frame_done period unchanged. Assert rst mid-slot → all outputs take reset values on the next edge, and an earlier pending load is not displayed.
